// File: rtl/mtm_riscv_gpio_cond.sv
// GPIO conditioning between pads and the core: debounced inputs with rise pulses,
// boot strap latching after reset, and registered outputs with an optional shared blink.
module mtm_riscv_gpio_cond #(
    parameter int N_IN       = 4,
    parameter int N_OUT      = 5,
    parameter int DEB_CYCLES = 16,
    parameter int STRAP_WAIT = 4,
    parameter int BLINK_W    = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IN-1:0]  pad_in,
    input  logic [1:0]       strap_in,
    output logic [N_IN-1:0]  core_in,
    output logic [N_IN-1:0]  core_in_rise,
    output logic [1:0]       strap_out,
    output logic             strap_valid,
    input  logic [N_OUT-1:0] core_out,
    input  logic [N_OUT-1:0] blink_en,
    output logic [N_OUT-1:0] pad_out
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int WW = $clog2(STRAP_WAIT + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(STRAP_WAIT - 1);

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_LATCH = 2'd1,
        S_DONE  = 2'd2
    } strap_state_t;

    logic [N_IN-1:0]    pad_s1;
    logic [N_IN-1:0]    pad_s2;
    logic [1:0]         strap_s1;
    logic [1:0]         strap_s2;
    logic [DW-1:0]      deb_cnt [N_IN];
    strap_state_t       state_q;
    strap_state_t       state_d;
    logic [WW-1:0]      wait_cnt_q;
    logic [WW-1:0]      wait_cnt_d;
    logic               latch_en;
    logic [BLINK_W-1:0] prescaler;
    logic               phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_s1   <= '0;
            pad_s2   <= '0;
            strap_s1 <= '0;
            strap_s2 <= '0;
        end else begin
            pad_s1   <= pad_in;
            pad_s2   <= pad_s1;
            strap_s1 <= strap_in;
            strap_s2 <= strap_s1;
        end
    end

    // A channel flips only after DEB_CYCLES consecutive cycles of disagreement;
    // any agreeing cycle throws the partial count away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_IN; i++) begin
                deb_cnt[i] <= '0;
            end
            core_in      <= '0;
            core_in_rise <= '0;
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                core_in_rise[i] <= 1'b0;
                if (pad_s2[i] == core_in[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb_cnt[i]      <= '0;
                    core_in[i]      <= pad_s2[i];
                    core_in_rise[i] <= pad_s2[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_WAIT;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        latch_en   = 1'b0;
        case (state_q)
            S_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    wait_cnt_d = '0;
                    state_d    = S_LATCH;
                end else begin
                    wait_cnt_d = wait_cnt_q + WW'(1);
                end
            end
            S_LATCH: begin
                latch_en = 1'b1;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d    = S_WAIT;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Straps are captured once; later pad activity has no path to strap_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strap_out   <= '0;
            strap_valid <= 1'b0;
        end else if (latch_en) begin
            strap_out   <= strap_s2;
            strap_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + BLINK_W'(1);
        end
    end

    assign phase = prescaler[BLINK_W-1];

    // Outputs stay dark until the straps are known, so the core boots before driving pads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_out <= '0;
        end else if (!strap_valid) begin
            pad_out <= '0;
        end else begin
            pad_out <= core_out & (~blink_en | {N_OUT{phase}});
        end
    end

endmodule

// File: tb/tb_mtm_riscv_gpio_cond.sv
// Bench for mtm_riscv_gpio_cond: edge-counting reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mtm_riscv_gpio_cond;

    localparam int N_IN  = 4;
    localparam int N_OUT = 5;
    localparam int DEB   = 4;
    localparam int SW    = 4;
    localparam int BW    = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N_IN-1:0]  pad_in;
    logic [1:0]       strap_in;
    logic [N_IN-1:0]  core_in;
    logic [N_IN-1:0]  core_in_rise;
    logic [1:0]       strap_out;
    logic             strap_valid;
    logic [N_OUT-1:0] core_out;
    logic [N_OUT-1:0] blink_en;
    logic [N_OUT-1:0] pad_out;

    mtm_riscv_gpio_cond #(
        .N_IN(N_IN), .N_OUT(N_OUT), .DEB_CYCLES(DEB), .STRAP_WAIT(SW), .BLINK_W(BW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pad_in(pad_in), .strap_in(strap_in),
        .core_in(core_in), .core_in_rise(core_in_rise), .strap_out(strap_out),
        .strap_valid(strap_valid), .core_out(core_out), .blink_en(blink_en),
        .pad_out(pad_out)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: time measured in edges since reset release.
    int               m_edges;
    int               m_presc;
    bit               m_phase;
    int               m_run [N_IN];
    logic [N_IN-1:0]  m_p1, m_p2, m_core, m_rise;
    logic [1:0]       m_t1, m_t2, m_strap;
    logic             m_valid;
    logic [N_OUT-1:0] m_pad;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_edges = 0;
            m_p1 = '0; m_p2 = '0; m_core = '0; m_rise = '0;
            m_t1 = '0; m_t2 = '0; m_strap = '0; m_valid = 1'b0; m_pad = '0;
            for (int i = 0; i < N_IN; i++) m_run[i] = 0;
        end else begin
            m_edges++;
            m_presc = (m_edges - 1) % (1 << BW);
            m_phase = (m_presc >= (1 << (BW - 1)));
            for (int j = 0; j < N_OUT; j++)
                m_pad[j] = m_valid && core_out[j] && (!blink_en[j] || m_phase);
            if (m_edges == SW + 1) begin
                m_strap = m_t2;
                m_valid = 1'b1;
            end
            for (int i = 0; i < N_IN; i++) begin
                m_rise[i] = 1'b0;
                if (m_p2[i] != m_core[i]) m_run[i]++;
                else m_run[i] = 0;
                if (m_run[i] == DEB) begin
                    m_core[i] = m_p2[i];
                    m_rise[i] = m_p2[i];
                    m_run[i]  = 0;
                end
            end
            m_t2 = m_t1; m_t1 = strap_in;
            m_p2 = m_p1; m_p1 = pad_in;
        end
        #1;
        chk("model_core_in", core_in, m_core);
        chk("model_rise", core_in_rise, m_rise);
        chk("model_strap_out", strap_out, m_strap);
        chk("model_strap_valid", strap_valid, m_valid);
        chk("model_pad_out", pad_out, m_pad);
    end

    // Directed scenarios
    int         ones0, ones4;
    logic [3:0] acc_core, acc_rise;

    initial begin
        rst_n = 1'b0; pad_in = '0; strap_in = 2'b10;
        core_out = 5'b10001; blink_en = 5'b00001;
        step(3);
        chk("rst_core_in", core_in, 0);
        chk("rst_rise", core_in_rise, 0);
        chk("rst_strap_out", strap_out, 0);
        chk("rst_strap_valid", strap_valid, 0);
        chk("rst_pad_out", pad_out, 0);

        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step(1);
            if (k == 4) begin
                chk("strap_valid_edge4", strap_valid, 0);
                chk("pad_out_edge4", pad_out, 0);
            end
        end
        chk("strap_valid_edge5", strap_valid, 1);
        chk("strap_out_edge5", strap_out, 2'b10);
        chk("pad_out_edge5", pad_out, 0);
        strap_in = 2'b01;
        step(8);
        chk("strap_hold", strap_out, 2'b10);

        ones0 = 0; ones4 = 0;
        for (int k = 0; k < 32; k++) begin
            step(1);
            ones0 += int'(pad_out[0]);
            ones4 += int'(pad_out[4]);
        end
        chk("blink_ones_ch0", ones0, 16);
        chk("steady_ones_ch4", ones4, 32);

        pad_in[0] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step(1);
            if (k == 5) chk("deb0_edge5", core_in[0], 0);
            if (k == 6) begin
                chk("deb0_edge6", core_in[0], 1);
                chk("rise0_edge6", core_in_rise, 4'b0001);
            end
            if (k == 7) chk("rise0_edge7", core_in_rise, 0);
        end
        pad_in[0] = 1'b0;
        acc_rise = '0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            acc_rise |= core_in_rise;
        end
        chk("fall0_no_rise", acc_rise, 0);
        chk("fall0_core_in", core_in, 0);

        pad_in[2] = 1'b1;
        acc_core = '0; acc_rise = '0;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            if (k == 3) pad_in[2] = 1'b0;
            acc_core |= core_in;
            acc_rise |= core_in_rise;
        end
        chk("glitch2_core_in", acc_core, 0);
        chk("glitch2_rise", acc_rise, 0);

        pad_in[1] = 1'b1;
        step(4);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_core_in", core_in, 0);
        chk("arst_strap_valid", strap_valid, 0);
        chk("arst_strap_out", strap_out, 0);
        chk("arst_pad_out", pad_out, 0);
        step(2);
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step(1);
            if (k == 4) chk("rel1_valid_edge4", strap_valid, 0);
            if (k == 5) begin
                chk("rel1_valid_edge5", strap_valid, 1);
                chk("rel1_strap_out", strap_out, 2'b01);
                chk("rel1_deb_edge5", core_in[1], 0);
            end
            if (k == 6) begin
                chk("rel1_deb_edge6", core_in[1], 1);
                chk("rel1_rise_edge6", core_in_rise, 4'b0010);
            end
        end

        #2 rst_n = 1'b0;
        #1 chk("arst2_core_in", core_in, 0);
        step(1);
        rst_n = 1'b1;
        step(2);
        #2 rst_n = 1'b0;
        #1 chk("arst_wait_valid", strap_valid, 0);
        step(1);
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step(1);
            if (k == 4) chk("rel2_valid_edge4", strap_valid, 0);
            if (k == 5) chk("rel2_valid_edge5", strap_valid, 1);
            if (k == 6) chk("rel2_core_in", core_in, 4'b0010);
        end

        pad_in = ~pad_in;
        for (int k = 1; k <= 7; k++) begin
            step(1);
            if (k == 5) chk("all_edge5", core_in, 4'b0010);
            if (k == 6) begin
                chk("all_edge6", core_in, 4'b1101);
                chk("all_rise_edge6", core_in_rise, 4'b1101);
            end
            if (k == 7) chk("all_rise_edge7", core_in_rise, 0);
        end
        pad_in = ~pad_in;
        for (int k = 1; k <= 6; k++) begin
            step(1);
            if (k == 6) begin
                chk("back_edge6", core_in, 4'b0010);
                chk("back_rise_edge6", core_in_rise, 4'b0010);
            end
        end

        core_out = 5'b11111; blink_en = 5'b10001;
        step(12);
        blink_en = 5'b01110;
        step(12);
        core_out = 5'b01010;
        step(6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
